// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and default data width,
// used by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned BYTE_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_baud_rate_gen.sv
// Baud tick generator: one-cycle o_tick every DIVISOR clocks, phase
// realigned to zero by i_restart.
module baud_rate_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIVISOR = 1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned CNT_W = width_of(DIVISOR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (i_restart || (cnt_q == CNT_LAST)) cnt_d = '0;
    o_tick = (cnt_q == CNT_LAST);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, BYTE data bits LSB first, optional even
// parity bit (macro UART_TX_PARITY_EN), one stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned BYTE       = BYTE_DEFAULT,
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 19200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_tx_start,
  input  logic [BYTE-1:0] i_tx_data,
  output logic            o_tx,
  output logic            o_tx_done,
  output logic            o_busy
);

  localparam int unsigned DIVISOR = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned OS_W    = width_of(OVERSAMPLE);
  localparam int unsigned BIT_W   = width_of(BYTE);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BYTE - 1);

  if (DIVISOR == 0) begin : g_divisor_check
    $error("uart_tx: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 1");
  end

  uart_state_e      state_q, state_d;
  logic [BYTE-1:0]  shift_q, shift_d;
  logic [OS_W-1:0]  os_q, os_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             tick;
  logic             accept;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign accept  = (state_q == IDLE) && i_tx_start;
  assign bit_end = tick && (os_q == OS_LAST);

  baud_rate_gen #(
    .DIVISOR(DIVISOR)
  ) u_baud (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_restart(accept),
    .o_tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    os_d    = os_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    if (state_q != IDLE && tick) os_d = bit_end ? '0 : os_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (i_tx_start) begin
          state_d = START;
          shift_d = i_tx_data;
          os_d    = '0;
          bit_d   = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^i_tx_data;
`endif
        end
      end
      START: if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so o_tx stays a pure flop output.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      os_q    <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign o_tx      = tx_q;
  assign o_tx_done = done_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIVISOR=2 (32 clocks per bit); covers the
// UART_TX_PARITY_EN build as well when that macro is defined.
module tb_uart_tx;

  localparam int unsigned BIT_CLKS = 32;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  localparam int unsigned FRAME_CLKS = FRAME_BITS * BIT_CLKS;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       tx, done, busy;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx #(
    .BYTE      (8),
    .CLK_FREQ  (3200),
    .BAUD_RATE (100),
    .OVERSAMPLE(16)
  ) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_tx_start(start),
    .i_tx_data (data),
    .o_tx      (tx),
    .o_tx_done (done),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line level for frame bit idx of byte d.
  function automatic logic exp_bit(input logic [7:0] d, input int unsigned idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; data = 8'hA5;
    tick(); tick();
    n_cmp++; if (tx !== 1'b1)   begin n_bad++; $display("FAIL reset_tx got=%b want=1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", done); end
    rst = 1'b0; start = 1'b0;
    tick(); tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
    n_cmp++; if (tx !== 1'b1)   begin n_bad++; $display("FAIL reset_idle_tx got=%b want=1", tx); end
  endtask

  task automatic test_frame_a5();
    data = 8'hA5; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= int'(FRAME_CLKS); c++) begin
      if (c == 50) data = 8'h5A;
      n_cmp++;
      if (tx !== exp_bit(8'hA5, (c - 1) / BIT_CLKS)) begin
        n_bad++; $display("FAIL a5_tx cyc=%0d got=%b want=%b", c, tx, exp_bit(8'hA5, (c - 1) / BIT_CLKS));
      end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL a5_busy cyc=%0d got=%b want=1", c, busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL a5_early_done cyc=%0d got=%b want=0", c, done); end
      tick();
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL a5_done_at_end got=%b want=1", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL a5_busy_at_end got=%b want=0", busy); end
    n_cmp++; if (tx !== 1'b1)   begin n_bad++; $display("FAIL a5_tx_at_end got=%b want=1", tx); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL a5_done_width got=%b want=0", done); end
  endtask

  task automatic test_ignore_start();
    data = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= int'(FRAME_CLKS); c++) begin
      if (c == 100) begin start = 1'b1; data = 8'hFF; end
      if (c == 110) start = 1'b0;
      n_cmp++;
      if (tx !== exp_bit(8'h00, (c - 1) / BIT_CLKS)) begin
        n_bad++; $display("FAIL ign_tx cyc=%0d got=%b want=%b", c, tx, exp_bit(8'h00, (c - 1) / BIT_CLKS));
      end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ign_early_done cyc=%0d got=%b want=0", c, done); end
      tick();
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL ign_done got=%b want=1", done); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ign_second_done got=%b want=0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ign_restarted got=%b want=0", busy); end
  endtask

  task automatic test_reset_abort();
    data = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 150; c++) tick();
    n_cmp++; if (tx !== 1'b0) begin n_bad++; $display("FAIL abort_pre_tx got=%b want=0", tx); end
    rst = 1'b1;
    tick();
    n_cmp++; if (tx !== 1'b1)   begin n_bad++; $display("FAIL abort_tx got=%b want=1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    rst = 1'b0;
    for (int c = 0; c < 250; c++) begin
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL abort_done cyc=%0d got=%b want=0", c, done); end
      n_cmp++; if (tx !== 1'b1)   begin n_bad++; $display("FAIL abort_idle_tx cyc=%0d got=%b want=1", c, tx); end
      tick();
    end
    data = 8'h96; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= int'(FRAME_CLKS); c++) begin
      n_cmp++;
      if (tx !== exp_bit(8'h96, (c - 1) / BIT_CLKS)) begin
        n_bad++; $display("FAIL clean_tx cyc=%0d got=%b want=%b", c, tx, exp_bit(8'h96, (c - 1) / BIT_CLKS));
      end
      tick();
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL clean_done got=%b want=1", done); end
    tick();
  endtask

  task automatic test_back_to_back();
    data = 8'h3C; start = 1'b1;
    tick();
    data = 8'hC3;
    for (int c = 1; c <= int'(FRAME_CLKS); c++) begin
      n_cmp++;
      if (tx !== exp_bit(8'h3C, (c - 1) / BIT_CLKS)) begin
        n_bad++; $display("FAIL b2b_first_tx cyc=%0d got=%b want=%b", c, tx, exp_bit(8'h3C, (c - 1) / BIT_CLKS));
      end
      tick();
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_first_done got=%b want=1", done); end
    tick();
    start = 1'b0;
    for (int c = 1; c <= int'(FRAME_CLKS); c++) begin
      n_cmp++;
      if (tx !== exp_bit(8'hC3, (c - 1) / BIT_CLKS)) begin
        n_bad++; $display("FAIL b2b_second_tx cyc=%0d got=%b want=%b", c, tx, exp_bit(8'hC3, (c - 1) / BIT_CLKS));
      end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_second_busy cyc=%0d got=%b want=1", c, busy); end
      tick();
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_second_done got=%b want=1", done); end
    tick();
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] vec  [2] = '{8'h07, 8'h03};
    logic       par  [2] = '{1'b1, 1'b0};
    for (int v = 0; v < 2; v++) begin
      data = vec[v]; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= 352; c++) begin
        if (c == 9 * 32 + 16) begin
          n_cmp++;
          if (tx !== par[v]) begin n_bad++; $display("FAIL parity_bit v=%0d got=%b want=%b", v, tx, par[v]); end
        end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL parity_early_done v=%0d cyc=%0d got=%b", v, c, done); end
        tick();
      end
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL parity_done v=%0d got=%b want=1", v, done); end
      tick();
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; data = 8'h00;
    tick(); tick();
    test_reset();
    test_frame_a5();
    tick(); tick();
    test_ignore_start();
    tick();
    test_reset_abort();
    tick(); tick();
    test_back_to_back();
    tick();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter BYTE, default 8: data bits per frame.
REQ-002 SHALL have parameter CLK_FREQ, default 50_000_000: i_clock frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 19200: line bit rate.
REQ-004 SHALL have parameter OVERSAMPLE, default 16: baud ticks per bit.
REQ-005 SHALL have port i_clock, input, 1: the single clock.
REQ-006 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port i_tx_start, input, 1: request to send i_tx_data.
REQ-008 SHALL have port i_tx_data, input, BYTE: byte to transmit.
REQ-009 SHALL have port o_tx, output, 1: serial line, idle high.
REQ-010 SHALL have port o_tx_done, output, 1: one-cycle pulse when a frame completes.
REQ-011 SHALL have port o_busy, output, 1: high while a frame is in progress.

Function
REQ-012 SHALL derive DIVISOR = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) by integer division; DIVISOR < 1 SHALL be an elaboration error.
REQ-013 SHALL produce a one-cycle baud tick every DIVISOR clocks; the tick counter SHALL restart at zero in the cycle a start is accepted, so every bit lasts exactly OVERSAMPLE*DIVISOR clocks.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY SHALL be reachable only per REQ-026.
REQ-015 SHALL accept i_tx_start only in IDLE, latch i_tx_data into a shift register in that cycle, and enter START; i_tx_start outside IDLE SHALL be ignored.
REQ-016 SHALL drive o_tx registered: 1 in IDLE and STOP, 0 in START, shift-register LSB in DATA; o_tx SHALL go low the cycle after acceptance.
REQ-017 SHALL send data bits LSB first, shifting after every OVERSAMPLE ticks; a 3-bit-plus bit counter of width $clog2(BYTE) SHALL leave DATA after bit BYTE-1.
REQ-018 SHALL hold STOP for exactly one bit time (OVERSAMPLE ticks), then return to IDLE.
REQ-019 SHALL assert o_tx_done for exactly the first IDLE cycle after STOP; i_tx_start in that cycle SHALL be accepted (back-to-back frames, no idle gap beyond that cycle).
REQ-020 SHALL drive o_busy = (state != IDLE), registered with the state.
REQ-021 SHALL leave o_tx, o_busy, o_tx_done unaffected by i_tx_data changes after acceptance.

Reset
REQ-022 SHALL on i_reset (synchronous, active-high) set state IDLE, o_tx=1, o_tx_done=0, o_busy=0, tick/bit counters and shift register to 0.
REQ-023 SHALL abort any frame on reset mid-operation: o_tx high the next cycle, no o_tx_done pulse for the aborted frame.
REQ-024 SHALL give reset priority over i_tx_start in the same cycle.

Configuration
REQ-025 SHALL compile the parity feature under macro UART_TX_PARITY_EN.
REQ-026 With UART_TX_PARITY_EN defined, SHALL insert one even-parity bit (XOR of the data bits) in PARITY state between DATA and STOP, frame = BYTE+3 bits; without it, DATA SHALL go directly to STOP, frame = BYTE+2 bits, and no parity logic SHALL exist.

Structure
REQ-027 SHALL place the state encoding (localparams for IDLE/START/DATA/PARITY/STOP) and the BYTE default in a shared package uart_pkg, which the receiver also uses.
REQ-028 SHALL instantiate one sub-module baud_rate_gen (inputs i_clock, i_reset, i_restart; output o_tick; parameter DIVISOR).

Verification (CLK_FREQ=3200, BAUD_RATE=100, OVERSAMPLE=16 -> DIVISOR=2, 32 clocks/bit)
REQ-029 SHALL check: start with 0xA5, no parity -> o_tx = 0, 1,0,1,0,0,1,0,1, 1 (32 clocks each); o_tx_done pulses 321 clocks after acceptance.
REQ-030 SHALL check: i_tx_start asserted with 0xFF at clock 100 of a 0x00 frame -> ignored, line stays per 0x00 frame, exactly one o_tx_done.
REQ-031 SHALL check: i_reset at clock 150 of a frame -> o_tx=1, o_busy=0 next cycle, no o_tx_done, next start sends a clean frame.
REQ-032 SHALL check: i_tx_start held high across o_tx_done cycle with 0x3C then 0xC3 -> second start bit begins the cycle after the done pulse.
REQ-033 SHALL check, UART_TX_PARITY_EN defined: 0x07 -> parity bit 1, 0x03 -> parity bit 0; o_tx_done 353 clocks after acceptance.
